load_store_unit: RTL
====================

# load_store_unit

Memory-access initiator for the RV32I core. Sits between the MEM stage and the `memory` block. Accepts one load or store request per handshake and drives the memory's combinational-read / clocked-write port. Aligned accesses are issued as a single beat. Misaligned halfword and word accesses are split into sequential byte beats, then reassembled and sign- or zero-extended before a single response is returned.

## Interface

**Parameters**
- `DWIDTH`, default 32: data width.
- `AWIDTH`, default 32: address width.

**Ports**
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `req_valid_i`  in  1: request valid.
- `req_ready_o`  out  1: unit idle; a request is accepted when valid && ready.
- `req_we_i`  in  1: 1 = store, 0 = load.
- `req_addr_i`  in  AWIDTH: byte address.
- `req_wdata_i`  in  DWIDTH: store data, right-aligned.
- `req_size_i`  in  2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned_i`  in  1: zero-extend the load result (LBU/LHU).
- `resp_valid_o`  out  1: one-cycle completion pulse, for loads and stores.
- `resp_rdata_o`  out  DWIDTH: load result; 0 for stores and errors.
- `resp_err_o`  out  1: illegal size; qualified by `resp_valid_o`.
- `mem_addr_o`  out  AWIDTH: memory address.
- `mem_data_o`  out  DWIDTH: memory write data.
- `mem_read_en_o`  out  1: memory read enable.
- `mem_write_en_o`  out  1: memory write enable.
- `mem_size_o`  out  2: memory access size, same encoding as `req_size_i`.
- `mem_sign_extend_o`  out  1: memory sign-extend select.
- `mem_data_i`  in  DWIDTH: combinational memory read data.

## Operation

**States**
- IDLE:
  - `req_ready_o` = !rst.
  - On accept, register the request, latch beat count N and clear the beat counter k.
  - Size 11 goes to RESP with the error flag set. Otherwise go to BEAT.
- Beat count N:
  - Byte: N = 1.
  - Half: N = 1 if addr[0] = 0, else 2.
  - Word: N = 1 if addr[1:0] = 00, else 4.
- BEAT, single-beat case (N = 1):
  - Drive `mem_*` with the registered address, size, data and `sign_extend` = !unsigned.
  - Loads capture `mem_data_i` as the final result.
- BEAT, split case (N > 1):
  - Beat k drives `mem_addr_o` = addr + k, modulo 2^AWIDTH (wrap allowed).
  - `mem_size_o` = 00, `mem_sign_extend_o` = 0.
  - `mem_data_o` = {24'b0, wdata[8k+7:8k]}.
  - Loads capture `mem_data_i[7:0]` into assembly bits [8k+7:8k].
  - After the last beat, the assembled value is sign- or zero-extended from bit 15 (half) or passed through (word).
- BEAT transitions: k increments each cycle; at k = N-1 go to RESP.
- RESP: `resp_valid_o` = 1 for one cycle, then return to IDLE. Requests are not accepted in RESP.

**Memory port rules**
- `mem_read_en_o` = BEAT && !we.
- `mem_write_en_o` = BEAT && we.
- Outside BEAT, all `mem_*` outputs are 0.

**Reset**
- Reset (including mid-operation) forces IDLE and clears all registers.
- Both memory enables drop immediately.
- No response is produced for the aborted request.
- Byte writes already committed remain in memory.

**Reset values of outputs**
- `req_ready_o` = 0 while rst is high, 1 after release.
- All other outputs are 0.

## Timing

- Accept at edge E0. Beats occupy cycles E0+1 .. E0+N. `resp_valid_o` is high in cycle E0+N+1. Next accept is possible at the end of cycle E0+N+2.
- Illegal size: response in cycle E0+1, no memory enables.
- Store beats commit at the end of each beat cycle.
- Load data is registered at the end of each beat cycle.
- `resp_rdata_o` and `resp_err_o` are registered and valid only while `resp_valid_o` is high. They hold 0 otherwise.
- Request inputs are sampled only at accept; changes afterwards are ignored.

## Structure

- Shared package or `constants.svh` holds:
  - Size encodings `SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`.
  - `lsu_state_e` enum (IDLE, BEAT, RESP).
  - `PC_START` and `MEM_DEPTH`, which the bench needs for memory placement.
- Sub-module `load_extend` (combinational): takes assembled data, size and unsigned flag, and produces the extended result. It is reused by the single-beat and split paths.
- FSM, beat counter and request registers live in `load_store_unit`.

## Test plan

Memory preload: word at PC_START+0x10 = 0x8899AABB, word at PC_START+0x14 = 0x11223344.

1. Aligned LW at +0x10.
   - `mem_size_o` = 10 for exactly one cycle.
   - `resp_rdata_o` = 0x8899AABB with `resp_valid_o` in cycle E0+2.
2. Byte loads at +0x13.
   - LB: 0xFFFFFF88.
   - LBU: 0x00000088.
   - Each is one beat with `mem_sign_extend_o` matching the request.
3. Misaligned LW at +0x12.
   - Four byte beats at addresses +0x12..+0x15.
   - Result 0x33448899 in cycle E0+5.
4. Misaligned LH at +0x11.
   - Two beats.
   - LH gives 0xFFFF99AA; LHU gives 0x000099AA.
5. Misaligned SW of 0xDEADBEEF at +0x11.
   - Byte writes EF, BE, AD, DE.
   - Subsequent LW +0x10 returns 0xADBEEFBB.
   - Subsequent LW +0x14 returns 0x112233DE.
6. Illegal size and mid-operation reset.
   - Size 11: `resp_err_o` = 1, `resp_rdata_o` = 0, no memory enables, response in cycle E0+1.
   - rst asserted during beat 2 of a misaligned SW: state returns to IDLE asynchronously with no `resp_valid_o`; only the first byte changed in memory.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg
// Shared definitions for the load/store unit and the code that sits around it:
//   - access size encodings (same encoding on the request and memory sides)
//   - FSM state type
//   - memory placement constants for the instruction/data memory
//   - beat_count(): number of memory beats an access needs
package load_store_unit_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  // Base address of the memory image and its size in bytes (power of two).
  localparam logic [31:0] PC_START  = 32'h0000_1000;
  localparam int          MEM_DEPTH = 4096;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // Aligned accesses need one beat; misaligned halves and words are split
  // into one byte beat per byte.
  function automatic logic [2:0] beat_count(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
    logic [2:0] n;
    n = 3'd1;
    case (size)
      SIZE_HALF: n = addr_lo[0] ? 3'd2 : 3'd1;
      SIZE_WORD: n = (addr_lo == 2'b00) ? 3'd1 : 3'd4;
      default:   n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/load_store_unit_extend.sv
// load_extend
// Combinational load-result extension. Shared by the single-beat path (data
// straight from memory) and the split path (bytes assembled over several beats).
// Ports:
//   data_i     - raw / assembled load data, right-aligned
//   size_i     - access size (byte, half, word)
//   unsigned_i - 1 = zero-extend, 0 = sign-extend
//   data_o     - extended result
module load_extend #(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] data_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic [DWIDTH-1:0] data_o
);
  import load_store_unit_pkg::*;

  // Replicate the top bit of the accessed field unless the load is unsigned.
  always_comb begin
    data_o = data_i;
    case (size_i)
      SIZE_BYTE: data_o = {{(DWIDTH-8){~unsigned_i & data_i[7]}}, data_i[7:0]};
      SIZE_HALF: data_o = {{(DWIDTH-16){~unsigned_i & data_i[15]}}, data_i[15:0]};
      default:   data_o = data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
// Memory-access initiator between the MEM stage and the memory block. Takes
// one load/store per valid/ready handshake, issues aligned accesses as a single
// beat and misaligned halves/words as byte beats, then returns one response.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   req_valid_i / req_ready_o - request handshake
//   req_we_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i - request
//   resp_valid_o, resp_rdata_o, resp_err_o - one-cycle completion
//   mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o,
//   mem_size_o, mem_sign_extend_o      - memory port (clocked write)
//   mem_data_i                         - combinational memory read data
module load_store_unit #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  output logic              resp_valid_o,
  output logic [DWIDTH-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  output logic [1:0]        mem_size_o,
  output logic              mem_sign_extend_o,
  input  logic [DWIDTH-1:0] mem_data_i
);
  import load_store_unit_pkg::*;

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic [2:0]        nbeats_q, nbeats_d;
  logic [1:0]        beat_q, beat_d;
  logic [DWIDTH-1:0] asm_q, asm_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              accept;
  logic              split;
  logic              last_beat;
  logic [4:0]        lane;
  logic [DWIDTH-1:0] asm_merged;
  logic [DWIDTH-1:0] ext_in;
  logic [DWIDTH-1:0] ext_out;

  assign accept    = req_valid_i && req_ready_o;
  assign split     = (nbeats_q != 3'd1);
  assign last_beat = ({1'b0, beat_q} == (nbeats_q - 3'd1));
  assign lane      = {beat_q, 3'b000};

  // Assembly register with this beat's byte dropped into its lane, so the
  // final beat can be extended without waiting an extra cycle.
  always_comb begin
    asm_merged = asm_q;
    asm_merged[lane +: 8] = mem_data_i[7:0];
  end

  assign ext_in = split ? asm_merged : mem_data_i;

  load_extend #(.DWIDTH(DWIDTH)) u_extend (
    .data_i     (ext_in),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .data_o     (ext_out)
  );

  // State and request registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      nbeats_q   <= 3'd0;
      beat_q     <= 2'd0;
      asm_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      nbeats_q   <= nbeats_d;
      beat_q     <= beat_d;
      asm_q      <= asm_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic. rdata/err are cleared at accept and on leaving RESP so
  // the response outputs read 0 whenever resp_valid_o is low.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    nbeats_d   = nbeats_q;
    beat_d     = beat_q;
    asm_d      = asm_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d       = req_we_i;
          addr_d     = req_addr_i;
          wdata_d    = req_wdata_i;
          size_d     = req_size_i;
          unsigned_d = req_unsigned_i;
          nbeats_d   = beat_count(req_size_i, req_addr_i[1:0]);
          beat_d     = 2'd0;
          asm_d      = '0;
          rdata_d    = '0;
          err_d      = (req_size_i == SIZE_ILLEGAL);
          state_d    = (req_size_i == SIZE_ILLEGAL) ? RESP : BEAT;
        end
      end
      BEAT: begin
        if (!we_q) begin
          asm_d = asm_merged;
        end
        if (last_beat) begin
          state_d = RESP;
          if (!we_q) begin
            rdata_d = ext_out;
          end
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory port: all zero outside BEAT. Split beats are always unextended
  // byte accesses at addr + k; the byte for lane k is right-aligned.
  always_comb begin
    mem_addr_o        = '0;
    mem_data_o        = '0;
    mem_read_en_o     = 1'b0;
    mem_write_en_o    = 1'b0;
    mem_size_o        = 2'b00;
    mem_sign_extend_o = 1'b0;
    if (state_q == BEAT) begin
      mem_read_en_o  = !we_q;
      mem_write_en_o = we_q;
      if (split) begin
        mem_addr_o = addr_q + AWIDTH'(beat_q);
        mem_data_o = {{(DWIDTH-8){1'b0}}, wdata_q[lane +: 8]};
        mem_size_o = SIZE_BYTE;
      end else begin
        mem_addr_o        = addr_q;
        mem_data_o        = wdata_q;
        mem_size_o        = size_q;
        mem_sign_extend_o = !unsigned_q;
      end
    end
  end

  assign req_ready_o  = (state_q == IDLE) && !rst;
  assign resp_valid_o = (state_q == RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;

endmodule
